// File: rtl/cs_pkg.sv
// Shared definitions for the CS-FEC receive path: collector FSM states,
// index-width helper and statistics counter width.
package cs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } cs_rx_state_t;

  localparam int CS_STAT_W = 16;

  // A single-symbol block still needs a one-bit index port.
  function automatic int cs_idx_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/cs_rx_timer.sv
// Clearable idle counter for the receive collector. tc pulses on the cycle
// whose increment brings the count to TIMEOUT.
module cs_rx_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Firing on the increment (not the held value) gives a close exactly
  // TIMEOUT idle cycles after the last accepted beat.
  assign tc = inc && !clr && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cs_rx_collector.sv
// Receive-side symbol collector: assembles K coded symbols plus an erasure
// mask for the CS-FEC decoder. Optional counters via CS_RX_STATS_EN.
//
// Handshakes: a beat transfers on a rising clk edge where in_valid && in_ready;
// a block transfers where out_valid && out_ready. Producers hold their data
// stable while valid is high and not yet accepted.
module cs_rx_collector
  import cs_pkg::*;
#(
  parameter int M       = 2,
  parameter int K       = 3,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [cs_idx_w(K)-1:0] in_idx,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [K*WIDTH-1:0]     out_coded,
  output logic [K-1:0]           out_erasure,
  output logic                   out_recoverable,
  output logic                   out_timeout,
  output logic [1:0]             dbg_state
`ifdef CS_RX_STATS_EN
  ,
  output logic [CS_STAT_W-1:0]   stat_blocks,
  output logic [CS_STAT_W-1:0]   stat_unrecov,
  output logic [CS_STAT_W-1:0]   stat_drops
`endif
);

  localparam int IW = cs_idx_w(K);

  cs_rx_state_t        state_q, state_d;
  logic [K-1:0]        recv_q, recv_d;
  logic [K*WIDTH-1:0]  data_q, data_d;
  logic                tmo_q, tmo_d;

  logic                accept;
  logic [K-1:0]        hit;
  logic [K-1:0]        wr;
  logic                full;
  logic                drop;
  logic                tmr_clr, tmr_inc, tmr_tc;
  logic [3:0]          era_cnt;

  assign in_ready  = (state_q != EMIT);
  assign out_valid = (state_q == EMIT);
  assign accept    = in_valid && in_ready;

  always_comb begin
    hit = '0;
    for (int i = 0; i < K; i++) begin
      hit[i] = (in_idx == IW'(i));
    end
  end

  // Only the first beat for a slot is written; an all-zero hit means the
  // index is out of range.
  assign wr   = accept ? (hit & ~recv_q) : '0;
  assign full = &(recv_q | wr);
  assign drop = accept && (((hit & recv_q) != '0) || (hit == '0));

  assign tmr_clr = accept || (state_q != COLLECT);
  assign tmr_inc = (state_q == COLLECT) && !accept;

  cs_rx_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(tmr_clr),
    .inc(tmr_inc),
    .tc (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    recv_d  = recv_q | wr;
    data_d  = data_q;
    tmo_d   = tmo_q;
    for (int i = 0; i < K; i++) begin
      if (wr[i]) begin
        data_d[i*WIDTH +: WIDTH] = in_data;
      end
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (in_last || full) ? EMIT : COLLECT;
        end
      end
      COLLECT: begin
        // An accepted beat keeps the timer from expiring, so a closing beat
        // never reports a timeout.
        if (accept && (in_last || full)) begin
          state_d = EMIT;
        end else if (tmr_tc) begin
          state_d = EMIT;
          tmo_d   = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d = IDLE;
          recv_d  = '0;
          data_d  = '0;
          tmo_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      recv_q  <= '0;
      data_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      recv_q  <= recv_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    era_cnt = '0;
    for (int i = 0; i < K; i++) begin
      era_cnt = era_cnt + 4'(!recv_q[i]);
    end
  end

  assign out_coded       = data_q;
  assign out_erasure     = ~recv_q;
  assign out_recoverable = (era_cnt <= 4'(K - M));
  assign out_timeout     = tmo_q;
  assign dbg_state       = state_q;

`ifdef CS_RX_STATS_EN
  logic [CS_STAT_W-1:0] blocks_q, unrecov_q, drops_q;
  logic                 emit_hs;

  assign emit_hs = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      blocks_q  <= '0;
      unrecov_q <= '0;
      drops_q   <= '0;
    end else begin
      if (emit_hs && (blocks_q != '1)) begin
        blocks_q <= blocks_q + CS_STAT_W'(1);
      end
      if (emit_hs && !out_recoverable && (unrecov_q != '1)) begin
        unrecov_q <= unrecov_q + CS_STAT_W'(1);
      end
      if (drop && (drops_q != '1)) begin
        drops_q <= drops_q + CS_STAT_W'(1);
      end
    end
  end

  assign stat_blocks  = blocks_q;
  assign stat_unrecov = unrecov_q;
  assign stat_drops   = drops_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
